mem_bus_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache (block refills) and the data cache (refills and write-backs) of the 5-stage RV32IM pipeline.
- Sits between the two caches and main memory. The caches raise their memory requests independently on a miss; the arbiter sequences them one at a time.
- It holds the losing cache in busywait, which stalls the PC and pipeline registers through the CPU's combined busywait.

---
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares the single main-memory port between the I-cache (refills) and the D-cache
// (refills and write-backs). One access at a time, round-robin on ties.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ICACHE_READ,
    input  logic [ADDR_WIDTH-1:0] ICACHE_ADDR,
    output logic [DATA_WIDTH-1:0] ICACHE_READDATA,
    output logic                  ICACHE_BUSYWAIT,
    input  logic                  DCACHE_READ,
    input  logic                  DCACHE_WRITE,
    input  logic [ADDR_WIDTH-1:0] DCACHE_ADDR,
    input  logic [DATA_WIDTH-1:0] DCACHE_WRITEDATA,
    output logic [DATA_WIDTH-1:0] DCACHE_READDATA,
    output logic                  DCACHE_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    // 1 when the most recent completed access belonged to the D-cache
    logic   last_d_q, last_d_d;

    logic req_i;
    logic req_d;

    assign req_i = ICACHE_READ;
    assign req_d = DCACHE_READ | DCACHE_WRITE;

    // Caches only latch on their own busywait-low cycle, so data is simply broadcast.
    assign ICACHE_READDATA = MEM_READDATA;
    assign DCACHE_READDATA = MEM_READDATA;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_d_d        = last_d_q;
        MEM_READ        = 1'b0;
        MEM_WRITE       = 1'b0;
        MEM_ADDR        = '0;
        MEM_WRITEDATA   = '0;
        ICACHE_BUSYWAIT = req_i;
        DCACHE_BUSYWAIT = req_d;

        case (state_q)
            IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_d_q ? GRANT_I : GRANT_D;
                end else if (req_d) begin
                    state_d = GRANT_D;
                end else if (req_i) begin
                    state_d = GRANT_I;
                end
            end

            GRANT_I: begin
                MEM_ADDR        = ICACHE_ADDR;
                // Strobe follows the request so a flush drops it in the same cycle.
                MEM_READ        = req_i;
                ICACHE_BUSYWAIT = MEM_BUSYWAIT;
                if (!req_i) begin
                    state_d = IDLE;
                end else if (!MEM_BUSYWAIT) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end

            GRANT_D: begin
                MEM_ADDR        = DCACHE_ADDR;
                MEM_WRITEDATA   = DCACHE_WRITEDATA;
                MEM_WRITE       = DCACHE_WRITE;
                MEM_READ        = DCACHE_READ & ~DCACHE_WRITE;
                DCACHE_BUSYWAIT = MEM_BUSYWAIT;
                if (!req_d) begin
                    state_d = IDLE;
                end else if (!MEM_BUSYWAIT) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          ICACHE_READ = 1'b0;
    logic [AW-1:0] ICACHE_ADDR = '0;
    logic [DW-1:0] ICACHE_READDATA;
    logic          ICACHE_BUSYWAIT;
    logic          DCACHE_READ = 1'b0;
    logic          DCACHE_WRITE = 1'b0;
    logic [AW-1:0] DCACHE_ADDR = '0;
    logic [DW-1:0] DCACHE_WRITEDATA = '0;
    logic [DW-1:0] DCACHE_READDATA;
    logic          DCACHE_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WRITEDATA;
    logic [DW-1:0] MEM_READDATA = '0;
    logic          MEM_BUSYWAIT = 1'b1;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .ICACHE_READ(ICACHE_READ), .ICACHE_ADDR(ICACHE_ADDR),
        .ICACHE_READDATA(ICACHE_READDATA), .ICACHE_BUSYWAIT(ICACHE_BUSYWAIT),
        .DCACHE_READ(DCACHE_READ), .DCACHE_WRITE(DCACHE_WRITE), .DCACHE_ADDR(DCACHE_ADDR),
        .DCACHE_WRITEDATA(DCACHE_WRITEDATA), .DCACHE_READDATA(DCACHE_READDATA),
        .DCACHE_BUSYWAIT(DCACHE_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic clr_inputs();
        ICACHE_READ = 1'b0; DCACHE_READ = 1'b0; DCACHE_WRITE = 1'b0;
        ICACHE_ADDR = '0; DCACHE_ADDR = '0; DCACHE_WRITEDATA = '0;
        MEM_BUSYWAIT = 1'b1; MEM_READDATA = '0;
    endtask

    // Leaves the bench just after a negedge with the DUT in IDLE and last grant = I.
    task automatic do_reset();
        @(negedge CLK);
        clr_inputs();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        clr_inputs();
        RESET = 1'b1; ICACHE_READ = 1'b1; ICACHE_ADDR = 28'h0ABCDEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK); #1;
            total++;
            if ({MEM_READ, MEM_WRITE, ICACHE_BUSYWAIT, MEM_ADDR} !== {3'b001, 28'h0}) begin
                bad++;
                $display("FAIL reset_hold[%0d]: rd/wr/ibw/addr got %b%b%b/%h want 001/0000000",
                         k, MEM_READ, MEM_WRITE, ICACHE_BUSYWAIT, MEM_ADDR);
            end
        end
        RESET = 1'b0;
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR} !== {2'b11, 28'h0ABCDEF}) begin
            bad++;
            $display("FAIL reset_release_grant_i: rd/ibw/addr got %b%b/%h want 11/0abcdef",
                     MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR);
        end
    endtask

    task automatic test_lone_irefill();
        logic [DW-1:0] pat;
        logic          eb;
        pat = {32'hDEADBEEF, 32'h0, 32'h0, 32'h1};
        do_reset();
        ICACHE_READ = 1'b1; ICACHE_ADDR = 28'h0000010;
        #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT} !== 2'b01) begin
            bad++;
            $display("FAIL irefill_idle: rd/ibw got %b%b want 01", MEM_READ, ICACHE_BUSYWAIT);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            eb = (k < 5);
            MEM_BUSYWAIT = eb;
            MEM_READDATA = (k == 5) ? pat : '0;
            #1;
            total++;
            if ({MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR} !== {1'b1, eb, 28'h0000010}) begin
                bad++;
                $display("FAIL irefill_cycle[%0d]: rd/ibw/addr got %b%b/%h want 1%b/0000010",
                         k, MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR, eb);
            end
        end
        total++;
        if (ICACHE_READDATA !== pat) begin
            bad++;
            $display("FAIL irefill_data: got %h want %h", ICACHE_READDATA, pat);
        end
        // New request held straight after completion: one IDLE cycle must still appear.
        @(negedge CLK);
        MEM_BUSYWAIT = 1'b1; ICACHE_ADDR = 28'h0000014;
        #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT} !== 2'b01) begin
            bad++;
            $display("FAIL irefill_turnaround: rd/ibw got %b%b want 01", MEM_READ, ICACHE_BUSYWAIT);
        end
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, MEM_ADDR} !== {1'b1, 28'h0000014}) begin
            bad++;
            $display("FAIL irefill_regrant: rd/addr got %b/%h want 1/0000014", MEM_READ, MEM_ADDR);
        end
    endtask

    task automatic test_tie_after_reset();
        logic eb;
        do_reset();
        ICACHE_READ = 1'b1; ICACHE_ADDR = 28'h0000100;
        DCACHE_READ = 1'b1; DCACHE_ADDR = 28'h0000200;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            eb = (k < 2);
            MEM_BUSYWAIT = eb;
            #1;
            total++;
            if ({MEM_READ, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT, MEM_ADDR} !== {2'b11, eb, 28'h0000200}) begin
                bad++;
                $display("FAIL tie_d_first[%0d]: rd/ibw/dbw/addr got %b%b%b/%h want 11%b/0000200",
                         k, MEM_READ, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT, MEM_ADDR, eb);
            end
        end
        @(negedge CLK);
        DCACHE_READ = 1'b0; MEM_BUSYWAIT = 1'b1;
        #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT} !== 2'b01) begin
            bad++;
            $display("FAIL tie_idle_gap: rd/ibw got %b%b want 01", MEM_READ, ICACHE_BUSYWAIT);
        end
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, MEM_ADDR} !== {1'b1, 28'h0000100}) begin
            bad++;
            $display("FAIL tie_then_i: rd/addr got %b/%h want 1/0000100", MEM_READ, MEM_ADDR);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW:0] log_q[$];
        logic [AW:0] exp_q[3];
        int          mc;
        int          overlaps;
        logic        i_done, d_done;
        exp_q[0] = {1'b1, 28'h0000020};
        exp_q[1] = {1'b0, 28'h0000030};
        exp_q[2] = {1'b0, 28'h0000024};
        mc = 0; overlaps = 0; i_done = 1'b0; d_done = 1'b0;
        do_reset();
        ICACHE_READ = 1'b1; ICACHE_ADDR = 28'h0000030;
        DCACHE_WRITE = 1'b1; DCACHE_ADDR = 28'h0000020;
        DCACHE_WRITEDATA = {4{32'h11111111}};
        for (int c = 0; c < 40 && log_q.size() < 3; c++) begin
            if (c != 0) @(negedge CLK);
            // Caches react after the edge on which they saw busywait low.
            if (i_done) ICACHE_READ = 1'b0;
            if (d_done) begin
                if (DCACHE_WRITE) begin
                    DCACHE_WRITE = 1'b0; DCACHE_READ = 1'b1; DCACHE_ADDR = 28'h0000024;
                end else begin
                    DCACHE_READ = 1'b0;
                end
            end
            #1;
            if (MEM_READ && MEM_WRITE) overlaps++;
            if (MEM_READ || MEM_WRITE) begin
                MEM_BUSYWAIT = (mc < 2);
                mc++;
            end else begin
                MEM_BUSYWAIT = 1'b1;
                mc = 0;
            end
            #1;
            if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) log_q.push_back({MEM_WRITE, MEM_ADDR});
            i_done = ICACHE_READ && !ICACHE_BUSYWAIT;
            d_done = (DCACHE_READ || DCACHE_WRITE) && !DCACHE_BUSYWAIT;
        end
        total++;
        if (overlaps != 0) begin
            bad++;
            $display("FAIL b2b_overlap: read&write cycles got %0d want 0", overlaps);
        end
        total++;
        if (log_q.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: accesses got %0d want 3", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (log_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: {wr,addr} got %h want %h", i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_withdrawal();
        do_reset();
        DCACHE_READ = 1'b1; DCACHE_ADDR = 28'h0000040;
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, DCACHE_BUSYWAIT} !== 2'b11) begin
            bad++;
            $display("FAIL wd_grant: rd/dbw got %b%b want 11", MEM_READ, DCACHE_BUSYWAIT);
        end
        @(negedge CLK);
        DCACHE_READ = 1'b0;
        #1;
        total++;
        if ({MEM_READ, MEM_WRITE} !== 2'b00) begin
            bad++;
            $display("FAIL wd_drop: rd/wr got %b%b want 00", MEM_READ, MEM_WRITE);
        end
        @(negedge CLK);
        ICACHE_READ = 1'b1; ICACHE_ADDR = 28'h0000044; DCACHE_READ = 1'b1;
        #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT} !== 3'b011) begin
            bad++;
            $display("FAIL wd_idle: rd/ibw/dbw got %b%b%b want 011", MEM_READ, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT);
        end
        // Withdrawal did not record a D grant, so last grant is still I and D wins the tie.
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR} !== {2'b11, 28'h0000040}) begin
            bad++;
            $display("FAIL wd_tie: rd/ibw/addr got %b%b/%h want 11/0000040", MEM_READ, ICACHE_BUSYWAIT, MEM_ADDR);
        end
    endtask

    task automatic test_illegal_both();
        logic [DW-1:0] wd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        DCACHE_READ = 1'b1; DCACHE_WRITE = 1'b1; DCACHE_ADDR = 28'h0000050; DCACHE_WRITEDATA = wd;
        @(negedge CLK); #1;
        total++;
        if ({MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA} !== {2'b01, 28'h0000050, wd}) begin
            bad++;
            $display("FAIL illegal_both: rd/wr/addr got %b%b/%h data %h want 01/0000050 data %h",
                     MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA, wd);
        end
    endtask

    task automatic new_d_req();
        int r;
        r = int'($urandom_range(0, 15));
        DCACHE_READ      = (r <= 8);
        DCACHE_WRITE     = (r >= 8);
        DCACHE_ADDR      = AW'($urandom);
        DCACHE_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_random();
        int            owner;   // 0 = nobody, 1 = I-cache, 2 = D-cache
        int            last;    // side that completed most recently (1 or 2)
        logic          ri, rd, own_req, i_done, d_done;
        logic          e_rd, e_wr, e_ib, e_db;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        do_reset();
        owner = 0; last = 1; i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge CLK);
            RESET = ($urandom_range(0, 255) == 0);
            if (i_done) begin
                ICACHE_READ = ($urandom_range(0, 1) == 1); ICACHE_ADDR = AW'($urandom);
            end else if (ICACHE_READ && $urandom_range(0, 31) == 0) begin
                ICACHE_READ = 1'b0;
            end else if (!ICACHE_READ && $urandom_range(0, 2) == 0) begin
                ICACHE_READ = 1'b1; ICACHE_ADDR = AW'($urandom);
            end
            if (d_done) begin
                if ($urandom_range(0, 1) == 1) new_d_req();
                else begin DCACHE_READ = 1'b0; DCACHE_WRITE = 1'b0; end
            end else if ((DCACHE_READ || DCACHE_WRITE) && $urandom_range(0, 31) == 0) begin
                DCACHE_READ = 1'b0; DCACHE_WRITE = 1'b0;
            end else if (!(DCACHE_READ || DCACHE_WRITE) && $urandom_range(0, 2) == 0) begin
                new_d_req();
            end
            MEM_BUSYWAIT = ($urandom_range(0, 3) != 0);
            MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
            #1;
            ri = ICACHE_READ;
            rd = DCACHE_READ || DCACHE_WRITE;
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0; e_ib = ri; e_db = rd;
            if (owner == 1) begin
                e_addr = ICACHE_ADDR; e_rd = ri; e_ib = MEM_BUSYWAIT;
            end else if (owner == 2) begin
                e_addr = DCACHE_ADDR; e_wd = DCACHE_WRITEDATA;
                e_wr = DCACHE_WRITE; e_rd = DCACHE_READ && !DCACHE_WRITE; e_db = MEM_BUSYWAIT;
            end
            total++;
            if ({MEM_READ, MEM_WRITE, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT, MEM_ADDR} !==
                {e_rd, e_wr, e_ib, e_db, e_addr}) begin
                bad++;
                $display("FAIL rand_ctrl[%0d]: rd/wr/ibw/dbw/addr got %b%b%b%b/%h want %b%b%b%b/%h",
                         c, MEM_READ, MEM_WRITE, ICACHE_BUSYWAIT, DCACHE_BUSYWAIT, MEM_ADDR,
                         e_rd, e_wr, e_ib, e_db, e_addr);
            end
            total++;
            if ({MEM_WRITEDATA, ICACHE_READDATA, DCACHE_READDATA} !== {e_wd, MEM_READDATA, MEM_READDATA}) begin
                bad++;
                $display("FAIL rand_data[%0d]: wdata %h want %h, ird %h drd %h want %h",
                         c, MEM_WRITEDATA, e_wd, ICACHE_READDATA, DCACHE_READDATA, MEM_READDATA);
            end
            // Who owns the bus after this edge, from the sharing rules.
            if (RESET) begin
                owner = 0; last = 1;
            end else if (owner != 0) begin
                own_req = (owner == 1) ? ri : rd;
                if (own_req && !MEM_BUSYWAIT) last = owner;
                if (!own_req || !MEM_BUSYWAIT) owner = 0;
            end else if (ri && rd) begin
                owner = 3 - last;
            end else if (ri || rd) begin
                owner = ri ? 1 : 2;
            end
            i_done = ri && !ICACHE_BUSYWAIT && !RESET;
            d_done = rd && !DCACHE_BUSYWAIT && !RESET;
        end
        RESET = 1'b0;
    endtask

    initial begin
        clr_inputs();
        test_reset();
        test_lone_irefill();
        test_tie_after_reset();
        test_back_to_back();
        test_withdrawal();
        test_illegal_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
